// File: rtl/mem_pkg.sv
// Shared memory-interface definitions: transfer size codes, responder FSM states
// and the byte-lane address helper used by the control unit and the RAM responder.
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'b00,
        SIZE_HALF  = 2'b01,
        SIZE_WORD  = 2'b10,
        SIZE_WORD2 = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } mfc_state_e;

    localparam int MEM_BYTES = 256;

    // Byte address of lane idx for an access at base; wraps modulo 256.
    function automatic logic [7:0] lane_addr(input logic [7:0] base, input logic [1:0] idx);
        return base + {6'd0, idx};
    endfunction

endpackage

// File: rtl/ram_lane_align.sv
// Big-endian byte-lane steering: lane 0 is the byte at the access address,
// lane 3 the byte at address+3. Purely combinational.
module ram_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]      size,
    input  logic [31:0]     wdata,
    input  logic [3:0][7:0] rd_lanes,
    output logic [3:0][7:0] wr_lanes,
    output logic [3:0]      wr_mask,
    output logic [31:0]     rdata
);

    // Select lane data, lane enables and zero-extended read value per size code.
    always_comb begin
        wr_lanes = '0;
        wr_mask  = 4'b0000;
        rdata    = 32'h0000_0000;
        case (size_e'(size))
            SIZE_BYTE: begin
                wr_lanes[0] = wdata[7:0];
                wr_mask     = 4'b0001;
                rdata       = {24'h00_0000, rd_lanes[0]};
            end
            SIZE_HALF: begin
                wr_lanes[0] = wdata[15:8];
                wr_lanes[1] = wdata[7:0];
                wr_mask     = 4'b0011;
                rdata       = {16'h0000, rd_lanes[0], rd_lanes[1]};
            end
            default: begin
                wr_lanes[0] = wdata[31:24];
                wr_lanes[1] = wdata[23:16];
                wr_lanes[2] = wdata[15:8];
                wr_lanes[3] = wdata[7:0];
                wr_mask     = 4'b1111;
                rdata       = {rd_lanes[0], rd_lanes[1], rd_lanes[2], rd_lanes[3]};
            end
        endcase
    end

endmodule

// File: rtl/ram_mfc_responder.sv
// 256-byte big-endian RAM answering MOV requests with a delayed MFC handshake.
// The request is captured on acceptance; MOV must be seen low in IDLE before re-arming.
module ram_mfc_responder
    import mem_pkg::*;
#(
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic        MOV,
    input  logic        RW,
    input  logic [1:0]  SIZE,
    input  logic [7:0]  ADDR,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    logic [7:0]      mem_r [0:MEM_BYTES-1];
    mfc_state_e      state_r;
    logic [3:0]      count_r;
    logic            hold_r;
    logic            mfc_r;
    logic [31:0]     dout_r;
    logic            rw_r;
    logic [1:0]      size_r;
    logic [7:0]      addr_r;
    logic [31:0]     data_r;

    logic [3:0][7:0] rd_lanes_s;
    logic [3:0][7:0] wr_lanes_s;
    logic [3:0]      wr_mask_s;
    logic [31:0]     rdata_s;
    logic            wr_en_s;

    // Fetch the four bytes starting at the captured address (wrapping).
    always_comb begin
        rd_lanes_s = '0;
        for (int i = 0; i < 4; i++) begin
            rd_lanes_s[i] = mem_r[lane_addr(addr_r, 2'(i))];
        end
    end

    ram_lane_align u_align (
        .size     (size_r),
        .wdata    (data_r),
        .rd_lanes (rd_lanes_s),
        .wr_lanes (wr_lanes_s),
        .wr_mask  (wr_mask_s),
        .rdata    (rdata_s)
    );

    // A write commits only on the final WAIT edge with MOV still asserted.
    always_comb begin
        wr_en_s = 1'b0;
        if ((state_r == ST_WAIT) && MOV && (count_r == 4'd0) && !rw_r) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Byte storage update; enabled lanes only.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en_s && wr_mask_s[i]) begin
                mem_r[lane_addr(addr_r, 2'(i))] <= wr_lanes_s[i];
            end
        end
    end

    // Request FSM with wait counter, re-arm flag and registered MFC/DataOut.
    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            state_r <= ST_IDLE;
            count_r <= 4'd0;
            hold_r  <= 1'b0;
            mfc_r   <= 1'b0;
            dout_r  <= 32'h0000_0000;
            rw_r    <= 1'b0;
            size_r  <= 2'b00;
            addr_r  <= 8'h00;
            data_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hold_r) begin
                        if (!MOV) begin
                            hold_r <= 1'b0;
                        end
                    end else if (MOV) begin
                        rw_r    <= RW;
                        size_r  <= SIZE;
                        addr_r  <= ADDR;
                        data_r  <= DataIn;
                        count_r <= WAIT_INIT;
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!MOV) begin
                        count_r <= 4'd0;
                        state_r <= ST_IDLE;
                    end else if (count_r != 4'd0) begin
                        count_r <= count_r - 4'd1;
                    end else begin
                        mfc_r   <= 1'b1;
                        state_r <= ST_DONE;
                        if (rw_r) begin
                            dout_r <= rdata_s;
                        end
                    end
                end
                ST_DONE: begin
                    if (!MOV) begin
                        mfc_r   <= 1'b0;
                        hold_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    mfc_r   <= 1'b0;
                    count_r <= 4'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign MFC     = mfc_r;
    assign DataOut = dout_r;

endmodule

// File: tb/tb_ram_mfc_responder.sv
// Directed self-checking bench for ram_mfc_responder (WAIT_STATES = 2):
// latency, big-endian lanes, wrap, partial writes, abort, CLR and MOV hold/re-arm.
module tb_ram_mfc_responder;

    logic        clk;
    logic        CLR;
    logic        MOV;
    logic        RW;
    logic [1:0]  SIZE;
    logic [7:0]  ADDR;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MFC;

    int checks = 0;
    int errors = 0;

    ram_mfc_responder #(.WAIT_STATES(2), .INIT_FILE("")) dut (
        .clk     (clk),
        .CLR     (CLR),
        .MOV     (MOV),
        .RW      (RW),
        .SIZE    (SIZE),
        .ADDR    (ADDR),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .MFC     (MFC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Count edges after the capture edge until MFC rises (bounded); expect 3.
    task automatic wait_mfc(input string tag);
        int n;
        n = 0;
        @(posedge clk); #1;
        DataIn = 32'hDEAD_BEEF;
        ADDR   = ADDR + 8'h40;
        RW     = ~RW;
        SIZE   = ~SIZE;
        while (!MFC && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd3);
    endtask

    task automatic xfer(input string tag, input logic rw_i, input logic [1:0] size_i,
                        input logic [7:0] addr_i, input logic [31:0] data_i,
                        input logic [31:0] exp_out, input int hold);
        @(negedge clk);
        RW = rw_i; SIZE = size_i; ADDR = addr_i; DataIn = data_i; MOV = 1'b1;
        wait_mfc(tag);
        chk({tag, "_dout"}, DataOut, exp_out);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_mfc"}, {31'd0, MFC}, 32'd1);
        end
        @(negedge clk); MOV = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_mfc_off"}, {31'd0, MFC}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        CLR = 1'b0; MOV = 1'b0; RW = 1'b0; SIZE = 2'b00; ADDR = 8'h00; DataIn = 32'h0;
        #12;
        chk("rst_mfc", {31'd0, MFC}, 32'd0);
        chk("rst_dout", DataOut, 32'h0);
        @(negedge clk); CLR = 1'b1;
        @(posedge clk); #1;

        xfer("wr_word", 1'b0, 2'b10, 8'h10, 32'h1234_5678, 32'h0000_0000, 0);
        xfer("rd_word", 1'b1, 2'b10, 8'h10, 32'h0, 32'h1234_5678, 0);
        xfer("rd_byte11", 1'b1, 2'b00, 8'h11, 32'h0, 32'h0000_0034, 0);
        xfer("rd_half12", 1'b1, 2'b01, 8'h12, 32'h0, 32'h0000_5678, 0);

        // Wrap: bytes AA,BB,CC,DD land at FE,FF,00,01; DataOut must survive the write.
        xfer("wr_wrap", 1'b0, 2'b10, 8'hFE, 32'hAABB_CCDD, 32'h0000_5678, 0);
        xfer("rd_byte00", 1'b1, 2'b00, 8'h00, 32'h0, 32'h0000_00CC, 0);
        xfer("rd_byteFE", 1'b1, 2'b00, 8'hFE, 32'h0, 32'h0000_00AA, 0);
        xfer("rd_halfFF", 1'b1, 2'b01, 8'hFF, 32'h0, 32'h0000_BBCC, 0);

        xfer("wr_byte11", 1'b0, 2'b00, 8'h11, 32'hFFFF_FF99, 32'h0000_BBCC, 0);
        xfer("rd_after_b", 1'b1, 2'b10, 8'h10, 32'h0, 32'h1299_5678, 0);

        // Abort by dropping MOV after one WAIT cycle.
        @(negedge clk);
        RW = 1'b0; SIZE = 2'b10; ADDR = 8'h10; DataIn = 32'hFFFF_FFFF; MOV = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); MOV = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_mfc", {31'd0, MFC}, 32'd0);
        chk("abort_dout", DataOut, 32'h1299_5678);

        // Asynchronous CLR in the middle of WAIT.
        @(negedge clk);
        RW = 1'b0; SIZE = 2'b10; ADDR = 8'h10; DataIn = 32'hFFFF_FFFF; MOV = 1'b1;
        @(posedge clk);
        @(negedge clk); #2 CLR = 1'b0;
        #1;
        chk("clr_mfc", {31'd0, MFC}, 32'd0);
        chk("clr_dout", DataOut, 32'h0);
        MOV = 1'b0;
        #1 CLR = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("clr_mfc_after", {31'd0, MFC}, 32'd0);
        xfer("rd_after_abt", 1'b1, 2'b10, 8'h10, 32'h0, 32'h1299_5678, 0);

        // MOV held 5 cycles past MFC, then a quick re-raise must not retrigger.
        @(negedge clk);
        RW = 1'b1; SIZE = 2'b01; ADDR = 8'h12; MOV = 1'b1;
        wait_mfc("hold");
        chk("hold_dout", DataOut, 32'h0000_5678);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_mfc", {31'd0, MFC}, 32'd1);
        end
        @(negedge clk); MOV = 1'b0;
        @(posedge clk);
        @(negedge clk); MOV = 1'b1; RW = 1'b1; SIZE = 2'b00; ADDR = 8'h13;
        repeat (6) @(posedge clk);
        #1;
        chk("no_retrigger", {31'd0, MFC}, 32'd0);
        chk("no_retrig_do", DataOut, 32'h0000_5678);
        @(negedge clk); MOV = 1'b0;
        @(posedge clk);
        @(negedge clk); MOV = 1'b1;
        wait_mfc("rearm");
        chk("rearm_dout", DataOut, 32'h0000_0078);
        @(negedge clk); MOV = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;

        // Halfword write touches only two lanes; SIZE=11 reads as a word.
        xfer("wr_half12", 1'b0, 2'b01, 8'h12, 32'hFFFF_BEEF, 32'h0000_0078, 0);
        xfer("rd_size11", 1'b1, 2'b11, 8'h10, 32'h0, 32'h1299_BEEF, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
